// File: rtl/let_prop_monitor_if.sv
// Signal bundle between the stimulus source and the let_prop_monitor checker.
// The master drives the observed operands; the slave (the monitor) returns debug status.
interface let_prop_monitor_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8,
    parameter int CYC_W = 16
);
    logic             en;
    logic             clear;
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic [WIDTH-1:0] a_vec;
    logic [WIDTH-1:0] b_vec;
    logic             seq_match;
    logic             prop_fail;
    logic             eq_fail;
    logic [CNT_W-1:0] seq_count;
    logic [CNT_W-1:0] fail_count;
    logic             err_sticky;
    logic [1:0]       err_code;
    logic [CYC_W-1:0] first_fail_cyc;

    modport master (
        output en, clear, a, b, c, d, a_vec, b_vec,
        input  seq_match, prop_fail, eq_fail, seq_count, fail_count,
               err_sticky, err_code, first_fail_cyc
    );

    modport slave (
        input  en, clear, a, b, c, d, a_vec, b_vec,
        output seq_match, prop_fail, eq_fail, seq_count, fail_count,
               err_sticky, err_code, first_fail_cyc
    );
endinterface

// File: rtl/let_prop_monitor.sv
// Hardware evaluation of (a||b) ##1 b, same(c,d) |=> !same(c,d) and ones_match(a_vec,b_vec),
// with registered pulses, saturating counters and first-failure capture for on-chip debug.
module let_prop_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8,
    parameter int CYC_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    let_prop_monitor_if.slave mon
);

    logic             x_q, x_d;
    logic             same_q, same_d;
    logic             seq_match_q, seq_match_d;
    logic             prop_fail_q, prop_fail_d;
    logic             eq_fail_q, eq_fail_d;
    logic [CNT_W-1:0] seq_count_q, seq_count_d;
    logic [CNT_W-1:0] fail_count_q, fail_count_d;
    logic             err_sticky_q, err_sticky_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CYC_W-1:0] first_fail_cyc_q, first_fail_cyc_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;

    logic c_eq_d;
    logic any_fail;

    assign c_eq_d   = (mon.c == mon.d);
    assign any_fail = prop_fail_d | eq_fail_d;

    // Counters and capture consume the pulse values being registered on this same edge,
    // so a pulse and its accounting become visible in the same cycle.
    always_comb begin
        cyc_d            = cyc_q + CYC_W'(1);
        x_d              = mon.en & (mon.a | mon.b);
        same_d           = mon.en & c_eq_d;
        seq_match_d      = mon.en & x_q & mon.b;
        prop_fail_d      = mon.en & same_q & c_eq_d;
        eq_fail_d        = mon.en & (mon.a_vec != mon.b_vec);
        seq_count_d      = seq_count_q;
        fail_count_d     = fail_count_q;
        err_sticky_d     = err_sticky_q;
        err_code_d       = err_code_q;
        first_fail_cyc_d = first_fail_cyc_q;

        if (seq_match_d && (seq_count_q != {CNT_W{1'b1}})) begin
            seq_count_d = seq_count_q + CNT_W'(1);
        end
        if (any_fail && (fail_count_q != {CNT_W{1'b1}})) begin
            fail_count_d = fail_count_q + CNT_W'(1);
        end
        if (any_fail && !err_sticky_q) begin
            err_sticky_d     = 1'b1;
            err_code_d       = {eq_fail_d, prop_fail_d};
            first_fail_cyc_d = cyc_q;
        end

        // Clear wipes everything except the free-running cycle counter.
        if (mon.clear) begin
            x_d              = 1'b0;
            same_d           = 1'b0;
            seq_match_d      = 1'b0;
            prop_fail_d      = 1'b0;
            eq_fail_d        = 1'b0;
            seq_count_d      = '0;
            fail_count_d     = '0;
            err_sticky_d     = 1'b0;
            err_code_d       = 2'b00;
            first_fail_cyc_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_q            <= '0;
            x_q              <= 1'b0;
            same_q           <= 1'b0;
            seq_match_q      <= 1'b0;
            prop_fail_q      <= 1'b0;
            eq_fail_q        <= 1'b0;
            seq_count_q      <= '0;
            fail_count_q     <= '0;
            err_sticky_q     <= 1'b0;
            err_code_q       <= 2'b00;
            first_fail_cyc_q <= '0;
        end else begin
            cyc_q            <= cyc_d;
            x_q              <= x_d;
            same_q           <= same_d;
            seq_match_q      <= seq_match_d;
            prop_fail_q      <= prop_fail_d;
            eq_fail_q        <= eq_fail_d;
            seq_count_q      <= seq_count_d;
            fail_count_q     <= fail_count_d;
            err_sticky_q     <= err_sticky_d;
            err_code_q       <= err_code_d;
            first_fail_cyc_q <= first_fail_cyc_d;
        end
    end

    assign mon.seq_match      = seq_match_q;
    assign mon.prop_fail      = prop_fail_q;
    assign mon.eq_fail        = eq_fail_q;
    assign mon.seq_count      = seq_count_q;
    assign mon.fail_count     = fail_count_q;
    assign mon.err_sticky     = err_sticky_q;
    assign mon.err_code       = err_code_q;
    assign mon.first_fail_cyc = first_fail_cyc_q;

endmodule
